// File: rtl/coproc_pkg.sv
// Shared constants and encodings for the matrix coprocessor sequencer.
// Element k of a 200-bit matrix sits at bits 8k +: 8 (k = 5r + c).
package coproc_pkg;
    localparam int N      = 5;
    localparam int ELEM_W = 8;
    localparam int NELEM  = N * N;
    localparam int MAT_W  = NELEM * ELEM_W;
    localparam int IDX_W  = 5;

    typedef enum logic [2:0] {
        OP_ADD       = 3'b000,
        OP_SUB       = 3'b001,
        OP_MUL       = 3'b010,
        OP_TRANSPOSE = 3'b011,
        OP_SCALAR    = 3'b100
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_STORE, S_FINISH
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'b100;
    endfunction
endpackage

// File: rtl/ula_sequencer_if.sv
// Instruction, memory, ULA and status signals of the sequencer.
// slave = sequencer side, master = environment side.
interface ula_sequencer_if #(parameter int ADDR_W = 10);
    logic                         instr_valid;
    logic                         instr_ready;
    logic [2:0]                   instr_opcode;
    logic [ADDR_W-1:0]            instr_addr_a;
    logic [ADDR_W-1:0]            instr_addr_b;
    logic [ADDR_W-1:0]            instr_addr_c;
    logic [ADDR_W-1:0]            mem_addr;
    logic                         mem_rd_en;
    logic [7:0]                   mem_rdata;
    logic                         mem_wr_en;
    logic [7:0]                   mem_wdata;
    logic [2:0]                   alu_op;
    logic [coproc_pkg::MAT_W-1:0] alu_matriz_a;
    logic [coproc_pkg::MAT_W-1:0] alu_matriz_b;
    logic                         alu_start;
    logic [coproc_pkg::MAT_W-1:0] alu_result;
    logic                         alu_done;
    logic                         alu_overflow;
    logic                         busy;
    logic                         done;
    logic                         overflow;
    logic [1:0]                   err;

    modport slave (
        input  instr_valid, instr_opcode, instr_addr_a, instr_addr_b, instr_addr_c,
               mem_rdata, alu_result, alu_done, alu_overflow,
        output instr_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
               alu_op, alu_matriz_a, alu_matriz_b, alu_start,
               busy, done, overflow, err
    );

    modport master (
        output instr_valid, instr_opcode, instr_addr_a, instr_addr_b, instr_addr_c,
               mem_rdata, alu_result, alu_done, alu_overflow,
        input  instr_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
               alu_op, alu_matriz_a, alu_matriz_b, alu_start,
               busy, done, overflow, err
    );
endinterface

// File: rtl/mat_byte_buffer.sv
// 25-element byte matrix register: clear, byte-indexed write, full-width load,
// byte-indexed read. Out-of-range indices write nothing and read 0.
module mat_byte_buffer
    import coproc_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [ELEM_W-1:0] i_wdata,
    input  logic              i_ld,
    input  logic [MAT_W-1:0]  i_ld_data,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [ELEM_W-1:0] o_rdata,
    output logic [MAT_W-1:0]  o_mat
);
    localparam logic [IDX_W-1:0] C_NELEM = IDX_W'(NELEM);

    logic [NELEM-1:0][ELEM_W-1:0] r_mem;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                          r_mem <= '0;
        else if (i_clr)                        r_mem <= '0;
        else if (i_ld)                         r_mem <= i_ld_data;
        else if (i_we && i_wr_idx < C_NELEM)   r_mem[i_wr_idx] <= i_wdata;
    end

    assign o_rdata = (i_rd_idx < C_NELEM) ? r_mem[i_rd_idx] : '0;
    assign o_mat   = r_mem;
endmodule

// File: rtl/ula_sequencer.sv
// Sequencer between instruction port, byte memory and the 5x5 matrix ULA:
// loads A/B byte-by-byte, runs the ULA handshake, stores the result.
module ula_sequencer
    import coproc_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 64
) (
    input  logic           clock,
    input  logic           reset_n,
    ula_sequencer_if.slave bus
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] C_NELEM    = IDX_W'(NELEM);
    localparam logic [IDX_W-1:0] C_LAST     = IDX_W'(NELEM - 1);
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_e            r_state, w_next;
    logic [IDX_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_addr_a, r_addr_b, r_addr_c;
    logic              r_cap_vld, r_cap_b;
    logic [IDX_W-1:0]  r_cap_idx;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_ready, r_busy, r_done, r_ovf;
    logic [1:0]        r_err;

    logic              w_accept, w_rd, w_wr, w_alu_hit;
    logic [ADDR_W-1:0] w_addr;
    logic [IDX_W-1:0]  w_nb;
    logic [ELEM_W-1:0] w_res_byte, w_a_byte_unused, w_b_byte_unused;
    logic [MAT_W-1:0]  w_res_unused;

    assign w_accept  = bus.instr_valid && r_ready;
    assign w_alu_hit = (r_state == S_EXEC) && bus.alu_done;
    assign w_nb      = (r_op == OP_SCALAR) ? IDX_W'(1) : C_NELEM;

    // Reads are issued from the counter; the byte is captured the cycle after it returns.
    always_comb begin
        w_next = r_state;
        w_rd   = 1'b0;
        w_wr   = 1'b0;
        w_addr = '0;
        case (r_state)
            S_IDLE:
                if (w_accept) w_next = op_legal(bus.instr_opcode) ? S_LOAD_A : S_FINISH;
            S_LOAD_A: begin
                if (r_cnt < C_NELEM) begin
                    w_rd   = 1'b1;
                    w_addr = r_addr_a + ADDR_W'(r_cnt);
                end
                if (r_cnt == C_LAST && r_op != OP_TRANSPOSE) w_next = S_LOAD_B;
                else if (r_cnt == C_NELEM)                   w_next = S_EXEC;
            end
            S_LOAD_B: begin
                if (r_cnt < w_nb) begin
                    w_rd   = 1'b1;
                    w_addr = r_addr_b + ADDR_W'(r_cnt);
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC:
                if (bus.alu_done)              w_next = S_STORE;
                else if (r_tmo == C_TMO_LAST)  w_next = S_FINISH;
            S_STORE: begin
                w_wr   = 1'b1;
                w_addr = r_addr_c + ADDR_W'(r_cnt);
                if (r_cnt == C_LAST) w_next = S_FINISH;
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_addr_a  <= '0;
            r_addr_b  <= '0;
            r_addr_c  <= '0;
            r_cap_vld <= 1'b0;
            r_cap_b   <= 1'b0;
            r_cap_idx <= '0;
            r_tmo     <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_err     <= ERR_OK;
        end else begin
            r_state   <= w_next;
            r_done    <= 1'b0;
            r_cap_vld <= w_rd;
            r_cap_b   <= (r_state == S_LOAD_B);
            r_cap_idx <= r_cnt;
            r_tmo     <= (r_state == S_EXEC) ? r_tmo + 1'b1 : '0;
            case (r_state)
                S_IDLE:
                    if (w_accept) begin
                        r_op     <= bus.instr_opcode;
                        r_addr_a <= bus.instr_addr_a;
                        r_addr_b <= bus.instr_addr_b;
                        r_addr_c <= bus.instr_addr_c;
                        r_cnt    <= '0;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_ovf    <= 1'b0;
                        r_err    <= op_legal(bus.instr_opcode) ? ERR_OK : ERR_ILLEGAL;
                    end
                S_LOAD_A:
                    r_cnt <= (w_next == S_LOAD_B) ? '0 : r_cnt + 1'b1;
                S_LOAD_B:
                    r_cnt <= r_cnt + 1'b1;
                S_EXEC:
                    if (bus.alu_done) begin
                        r_ovf <= bus.alu_overflow;
                        r_cnt <= '0;
                    end else if (r_tmo == C_TMO_LAST) begin
                        r_err <= ERR_TIMEOUT;
                    end
                S_STORE:
                    r_cnt <= r_cnt + 1'b1;
                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    mat_byte_buffer u_buf_a (
        .i_clk(clock), .i_rst_n(reset_n), .i_clr(w_accept),
        .i_we(r_cap_vld && !r_cap_b), .i_wr_idx(r_cap_idx), .i_wdata(bus.mem_rdata),
        .i_ld(1'b0), .i_ld_data('0), .i_rd_idx('0),
        .o_rdata(w_a_byte_unused), .o_mat(bus.alu_matriz_a)
    );

    mat_byte_buffer u_buf_b (
        .i_clk(clock), .i_rst_n(reset_n), .i_clr(w_accept),
        .i_we(r_cap_vld && r_cap_b), .i_wr_idx(r_cap_idx), .i_wdata(bus.mem_rdata),
        .i_ld(1'b0), .i_ld_data('0), .i_rd_idx('0),
        .o_rdata(w_b_byte_unused), .o_mat(bus.alu_matriz_b)
    );

    mat_byte_buffer u_buf_res (
        .i_clk(clock), .i_rst_n(reset_n), .i_clr(w_accept),
        .i_we(1'b0), .i_wr_idx('0), .i_wdata('0),
        .i_ld(w_alu_hit), .i_ld_data(bus.alu_result), .i_rd_idx(r_cnt),
        .o_rdata(w_res_byte), .o_mat(w_res_unused)
    );

    assign bus.instr_ready = r_ready;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.overflow    = r_ovf;
    assign bus.err         = r_err;
    assign bus.alu_op      = r_op;
    assign bus.alu_start   = (r_state == S_EXEC);
    assign bus.mem_rd_en   = w_rd;
    assign bus.mem_wr_en   = w_wr;
    assign bus.mem_addr    = w_addr;
    assign bus.mem_wdata   = w_wr ? w_res_byte : '0;
endmodule

// File: tb/tb_ula_sequencer.sv
// Bench for ula_sequencer: byte memory model, behavioural ULA, and a write
// scoreboard filled from the bench's own memory image at instruction issue.
module tb_ula_sequencer;
    import coproc_pkg::*;

    typedef struct { logic [9:0] addr; logic [7:0] data; } wr_t;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    ula_sequencer_if #(.ADDR_W(10)) bus();

    ula_sequencer #(.ADDR_W(10), .TIMEOUT(64)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus)
    );

    logic [7:0] mem [0:1023];
    wr_t        sb [$];
    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int n_rd, n_wr, n_start, n_rise, n_done, n_both = 0;
    int first_rd, last_rd, first_start, done_cyc, acc_cyc;
    logic [MAT_W-1:0] b_at_start;
    logic ovf_at_done;
    logic [1:0] err_at_done;
    logic prev_start = 1'b0;
    int ula_lat = 1, ula_cnt = 0;
    bit ula_never = 0, ula_ovf = 0;

    task automatic check(input string tag, input logic [MAT_W-1:0] got, input logic [MAT_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ix(input int r, input int c);
        return 8 * (5 * r + c);
    endfunction

    function automatic logic [MAT_W-1:0] ula_fn(input logic [2:0] op, input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
        logic [MAT_W-1:0] res = '0;
        logic [7:0] acc;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                case (op)
                    3'b000: res[ix(r,c) +: 8] = a[ix(r,c) +: 8] + b[ix(r,c) +: 8];
                    3'b001: res[ix(r,c) +: 8] = a[ix(r,c) +: 8] - b[ix(r,c) +: 8];
                    3'b010: begin
                        acc = 8'h00;
                        for (int k = 0; k < 5; k++) acc = acc + a[ix(r,k) +: 8] * b[ix(k,c) +: 8];
                        res[ix(r,c) +: 8] = acc;
                    end
                    3'b011: res[ix(r,c) +: 8] = a[ix(c,r) +: 8];
                    3'b100: res[ix(r,c) +: 8] = a[ix(r,c) +: 8] * b[7:0];
                    default: res[ix(r,c) +: 8] = 8'h00;
                endcase
            end
        return res;
    endfunction

    function automatic logic [MAT_W-1:0] mat_from_mem(input logic [9:0] base, input int n);
        logic [MAT_W-1:0] m = '0;
        for (int k = 0; k < n; k++) m[8*k +: 8] = mem[10'(base + k)];
        return m;
    endfunction

    // Behavioural ULA: done after ula_lat cycles of start, result from the presented operands.
    always @(posedge clock) ula_cnt <= bus.alu_start ? ula_cnt + 1 : 0;
    assign bus.alu_done     = bus.alu_start && !ula_never && (ula_cnt == ula_lat);
    assign bus.alu_overflow = bus.alu_done && ula_ovf;
    assign bus.alu_result   = ula_fn(bus.alu_op, bus.alu_matriz_a, bus.alu_matriz_b);

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    always @(negedge clock) begin
        wr_t e;
        if (bus.mem_rd_en) begin
            if (n_rd == 0) first_rd = cyc;
            last_rd = cyc;
            n_rd++;
        end
        if (bus.mem_rd_en && bus.mem_wr_en) n_both++;
        if (bus.mem_wr_en) begin
            n_wr++;
            check("wr_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", bus.mem_addr, e.addr);
                check("wr_data", bus.mem_wdata, e.data);
            end
        end
        if (bus.alu_start) begin
            if (n_start == 0) begin
                first_start = cyc;
                b_at_start  = bus.alu_matriz_b;
            end
            if (!prev_start) n_rise++;
            n_start++;
        end
        prev_start = bus.alu_start;
        if (bus.done) begin
            n_done++;
            done_cyc    = cyc;
            ovf_at_done = bus.overflow;
            err_at_done = bus.err;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [9:0] a, input logic [9:0] b,
                         input logic [9:0] c, input bit expect_wr);
        int t = 0;
        logic [MAT_W-1:0] am, bm, rm;
        wr_t w;
        @(negedge clock);
        while (!bus.instr_ready && t < 100) begin @(negedge clock); t++; end
        check("issue_ready", bus.instr_ready, 1'b1);
        n_rd = 0; n_wr = 0; n_start = 0; n_rise = 0; n_done = 0;
        b_at_start = '1;
        bus.instr_valid  = 1'b1;
        bus.instr_opcode = op;
        bus.instr_addr_a = a;
        bus.instr_addr_b = b;
        bus.instr_addr_c = c;
        acc_cyc = cyc;
        if (expect_wr) begin
            am = mat_from_mem(a, 25);
            bm = (op == OP_SCALAR) ? mat_from_mem(b, 1) : (op == OP_TRANSPOSE) ? '0 : mat_from_mem(b, 25);
            rm = ula_fn(op, am, bm);
            for (int k = 0; k < 25; k++) begin
                w.addr = 10'(c + k);
                w.data = rm[8*k +: 8];
                sb.push_back(w);
            end
        end
        @(negedge clock);
        bus.instr_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int t = 0;
        while (n_done == 0 && t < budget) begin @(negedge clock); #1; t++; end
        check({tag, "_done_seen"}, n_done != 0, 1'b1);
        repeat (2) @(negedge clock);
        #1;
        check({tag, "_done_once"}, n_done, 1);
        check({tag, "_ready_back"}, bus.instr_ready, 1'b1);
    endtask

    initial begin
        int t;
        bus.instr_valid = 1'b0; bus.instr_opcode = '0;
        bus.instr_addr_a = '0; bus.instr_addr_b = '0; bus.instr_addr_c = '0;
        for (int k = 0; k < 1024; k++) mem[k] = 8'h00;
        for (int k = 0; k < 25; k++) begin
            mem[10'(16 + k)]  = 8'h01;
            mem[10'(256 + k)] = 8'h02;
            mem[10'(64 + k)]  = 8'($urandom);
            mem[10'(128 + k)] = 8'($urandom);
        end
        mem[10'h0FF] = 8'h07;

        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_ready", bus.instr_ready, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_strobes", {bus.mem_rd_en, bus.mem_wr_en, bus.alu_start}, 3'b000);
        check("rst_err_ovf", {bus.err, bus.overflow}, 3'b000);
        check("rst_matriz_a", bus.alu_matriz_a, '0);
        reset_n = 1'b1;

        // ADD with C wrapping past the top of memory
        issue(OP_ADD, 10'h010, 10'h100, 10'h3F0, 1'b1);
        wait_done("add", 200);
        check("add_nrd", n_rd, 50);
        check("add_rd_contig", last_rd - first_rd + 1, 50);
        check("add_start_after_rd", first_start - last_rd, 2);
        check("add_nwr", n_wr, 25);
        check("add_ovf", ovf_at_done, 1'b0);
        check("add_err", err_at_done, 2'b00);

        ula_lat = 5; ula_ovf = 1'b1;
        issue(OP_MUL, 10'h040, 10'h080, 10'h0C0, 1'b1);
        wait_done("mul", 200);
        check("mul_start_cycles", n_start, 6);
        check("mul_start_rises", n_rise, 1);
        check("mul_ovf", ovf_at_done, 1'b1);
        check("mul_nwr", n_wr, 25);
        ula_lat = 1; ula_ovf = 1'b0;

        issue(OP_TRANSPOSE, 10'h040, 10'h080, 10'h200, 1'b1);
        wait_done("tr", 200);
        check("tr_nrd", n_rd, 25);
        check("tr_b_zero", b_at_start, '0);
        check("tr_ovf", ovf_at_done, 1'b0);

        issue(OP_SCALAR, 10'h040, 10'h0FF, 10'h240, 1'b1);
        wait_done("sc", 200);
        check("sc_nrd", n_rd, 26);
        check("sc_b", b_at_start, 200'h07);

        issue(3'b111, 10'h040, 10'h080, 10'h280, 1'b0);
        wait_done("ill", 20);
        check("ill_activity", n_rd + n_wr + n_start, 0);
        check("ill_latency", done_cyc - acc_cyc, 2);
        check("ill_err", err_at_done, 2'b01);

        ula_never = 1'b1;
        issue(OP_ADD, 10'h010, 10'h100, 10'h300, 1'b0);
        wait_done("tmo", 300);
        check("tmo_start_cycles", n_start, 64);
        check("tmo_nwr", n_wr, 0);
        check("tmo_err", err_at_done, 2'b10);
        ula_never = 1'b0;

        // Reset while the store phase is writing element 10
        issue(OP_ADD, 10'h010, 10'h100, 10'h300, 1'b1);
        t = 0;
        while (n_wr < 10 && t < 200) begin @(negedge clock); #1; t++; end
        check("rst_mid_reached", n_wr, 10);
        @(posedge clock);
        #2;
        check("rst_mid_wr_pre", {bus.mem_wr_en, bus.mem_addr}, {1'b1, 10'h30A});
        reset_n = 1'b0;
        #1;
        check("rst_mid_wr_drop", bus.mem_wr_en, 1'b0);
        check("rst_mid_state", {bus.instr_ready, bus.busy, bus.alu_start, bus.mem_rd_en}, 4'b1000);
        check("rst_mid_addr", bus.mem_addr, '0);
        sb.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_mid_no_wr", n_wr, 10);

        issue(OP_ADD, 10'h010, 10'h100, 10'h340, 1'b1);
        @(negedge clock);
        check("busy_offer", bus.busy, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bus.instr_valid = 1'b1; bus.instr_opcode = 3'b111;
            @(negedge clock);
        end
        bus.instr_valid = 1'b0;
        wait_done("post", 200);
        check("post_nrd", n_rd, 50);
        check("post_nwr", n_wr, 25);
        check("post_err", err_at_done, 2'b00);
        check("sb_drained", sb.size(), 0);
        check("rd_wr_exclusive", n_both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ula_sequencer.md
Name: ula_sequencer

Overview:
- Control unit between the coprocessor instruction interface, the byte-wide data memory and the 5x5 matrix ULA (add/sub/multiply/transpose/scalar datapath, 200-bit operands, 8-bit signed elements).
- Accepts one instruction at a time, streams operand matrices from memory into 200-bit operand registers, and drives the ULA start/done handshake.
- Streams the 200-bit result back to memory, then reports completion, overflow and errors.

Parameters:
- ADDR_W, 10, memory byte-address width
- TIMEOUT, 64, maximum EXEC cycles waiting for alu_done before abort

Ports:
- clock  in  1  system clock; one clock domain
- reset_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer idle, can accept
- instr_opcode  in  3  000 ADD, 001 SUB, 010 MUL, 011 TRANSPOSE, 100 SCALAR; others illegal
- instr_addr_a / instr_addr_b / instr_addr_c  in  ADDR_W each  base addresses of A, B (or scalar byte), C
- mem_addr  out  ADDR_W  memory address
- mem_rd_en  out  1  read strobe; data returns next cycle
- mem_rdata  in  8  read data
- mem_wr_en  out  1  write strobe
- mem_wdata  out  8  write data
- alu_op  out  3  opcode presented to ULA
- alu_matriz_a / alu_matriz_b  out  200 each  operand registers
- alu_start  out  1  level start to ULA
- alu_result  in  200  ULA result
- alu_done  in  1  ULA completion pulse
- alu_overflow  in  1  ULA overflow flag, valid with alu_done
- busy  out  1  instruction in flight
- done  out  1  one-cycle completion pulse
- overflow  out  1  result overflow, valid from done
- err  out  2  00 ok, 01 illegal opcode, 10 timeout; valid from done

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, except instr_ready = 1. State IDLE.
- Reset mid-operation: alu_start and mem strobes drop immediately (asynchronously). No further writes occur; partial memory contents are left as-is.
- Element layout: element (r,c) sits at bits 40r+8c +: 8. Memory is row-major: byte k = 5r+c, at base+k.
- Accept: instr_valid && instr_ready latches opcode and addresses. instr_ready and busy change on the next edge.
  - instr_valid while busy is ignored.
- States: IDLE -> LOAD_A -> LOAD_B -> EXEC -> STORE -> FINISH -> IDLE.
- LOAD_A: issues 25 reads on consecutive cycles (addr_a+0 .. addr_a+24). Each returned byte is written to element k of the A register one cycle later.
- LOAD_B:
  - ADD/SUB/MUL: 25 reads at addr_b, with no bubble after LOAD_A.
  - SCALAR: one read at addr_b; byte goes to element 0 of B, other B elements are 0.
  - TRANSPOSE: LOAD_B is skipped and B is held at 0.
- EXEC: entered once the final read data has been captured.
  - alu_start asserts on the entry cycle and stays high until the cycle alu_done is sampled high.
  - On that edge: capture alu_result and alu_overflow, drop alu_start (low at least 1 cycle), go to STORE.
  - alu_done outside EXEC is ignored.
- Timeout: if TIMEOUT cycles pass in EXEC without alu_done, drop alu_start, set err=10, skip STORE, go to FINISH.
- STORE: 25 writes on consecutive cycles to addr_c+k, mem_wdata = element k of the result.
- FINISH: done high for exactly one cycle with overflow and err valid; instr_ready returns to 1 next cycle.
  - overflow and err hold until the next accept, which clears them.
- Illegal opcode: no memory or ULA activity. Go IDLE -> FINISH with err=01, so done pulses 2 cycles after accept.
- Address wrap: base+k wraps modulo 2^ADDR_W.
- mem_rd_en and mem_wr_en are never high in the same cycle.

Decomposition:
- Package coproc_pkg:
  - opcode constants
  - N=5, ELEM_W=8, NELEM=25, MAT_W=200
  - state encoding
  - err codes
- Sub-module mat_byte_buffer: 200-bit register with indexed 8-bit write (load path) and indexed 8-bit read (store path), driven by the 5-bit element counter. Instantiated for A, B and result.

Test Plan:
- ADD, A = all 1, B = all 2, ULA model done 1 cycle after start:
  - exactly 50 contiguous mem_rd_en cycles, then alu_start
  - 25 writes of 3 to addr_c..addr_c+24
  - done pulse, overflow=0, err=00
- MUL, ULA model held busy 5 cycles with alu_overflow=1:
  - alu_start high continuously until done, low the following cycle
  - overflow=1 at done
- TRANSPOSE and SCALAR:
  - TRANSPOSE: 25 reads only
  - SCALAR: 26 reads, alu_matriz_b = 8'h07 in element 0 (scalar byte 7), zeros elsewhere
- Opcode 111: no mem strobes, no alu_start, done 2 cycles after accept, err=01.
- ULA model never asserts alu_done: after 64 EXEC cycles alu_start drops, no writes, err=10.
- reset_n low during STORE at write k=10: mem_wr_en drops immediately, outputs at reset values. A following ADD completes correctly; instr_valid offered while busy is not accepted.
